// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared widths, bank/state encodings and accumulator sizing for fir_lpf_param
package fir_pkg;

    localparam int DEF_NTAPS      = 31;
    localparam int DEF_ADDR_W     = 5;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_COEFF_W    = 10;
    localparam int DEF_COEFF_FRAC = 10;

    // Entries held per coefficient bank; any tap index beyond this reads as zero.
    localparam int BANK_TAPS      = 31;

    localparam logic BANK_WN0625 = 1'b0;
    localparam logic BANK_WN0075 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } fir_state_t;

    function automatic int acc_width(input int data_w, input int coeff_w, input int ntaps);
        return data_w + coeff_w + $clog2(ntaps);
    endfunction

endpackage

// File: rtl/lpf_coeff_bank.sv
// rtl/lpf_coeff_bank.sv - combinational ROM holding the Wn .0625 and Wn .0075 31-tap low-pass tables
module lpf_coeff_bank
    import fir_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int COEFF_W = DEF_COEFF_W
) (
    input  logic [ADDR_W-1:0]         i_index,
    input  logic [0:0]                i_bank,
    output logic signed [COEFF_W-1:0] o_coeff
);

    // Symmetric Hamming-windowed sinc taps scaled by 1024; sums are 1023 and 1021.
    localparam int WN0625_TBL [BANK_TAPS] = '{
        0, 1, 2, 4, 7, 11, 17, 25, 33, 42, 51, 60, 68, 74, 77, 79,
        77, 74, 68, 60, 51, 42, 33, 25, 17, 11, 7, 4, 2, 1, 0
    };
    localparam int WN0075_TBL [BANK_TAPS] = '{
        5, 6, 7, 10, 14, 19, 25, 31, 37, 43, 48, 53, 58, 61, 62, 63,
        62, 61, 58, 53, 48, 43, 37, 31, 25, 19, 14, 10, 7, 6, 5
    };

    logic [4:0] w_idx;
    logic       w_in_range;

    assign w_idx      = i_index[4:0];
    assign w_in_range = (i_index < ADDR_W'(BANK_TAPS));

    always_comb begin
        o_coeff = '0;
        if (w_in_range) begin
            if (i_bank == BANK_WN0625) begin
                o_coeff = COEFF_W'(WN0625_TBL[w_idx]);
            end else begin
                o_coeff = COEFF_W'(WN0075_TBL[w_idx]);
            end
        end
    end

endmodule

// File: rtl/fir_lpf_param.sv
// rtl/fir_lpf_param.sv - sequential-MAC low-pass FIR over a circular sample buffer; FIR_SYM_FOLD_EN folds symmetric taps
module fir_lpf_param
    import fir_pkg::*;
#(
    parameter int NTAPS      = DEF_NTAPS,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int COEFF_W    = DEF_COEFF_W,
    parameter int COEFF_FRAC = DEF_COEFF_FRAC
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     ready,
    input  logic signed [DATA_W-1:0] x,
    input  logic                     bank_sel,
    output logic signed [DATA_W-1:0] y,
    output logic                     y_valid,
    output logic                     busy,
    output logic                     overrun
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int ACC_W = acc_width(DATA_W, COEFF_W, NTAPS);
`ifdef FIR_SYM_FOLD_EN
    localparam int MUL_W  = DATA_W + 1;
    localparam int LAST_K = (NTAPS - 1) / 2;
`else
    localparam int MUL_W  = DATA_W;
    localparam int LAST_K = NTAPS - 1;
`endif
    localparam int PROD_W = MUL_W + COEFF_W;

    fir_state_t               r_state;
    fir_state_t               w_next_state;
    logic [ADDR_W-1:0]        r_offset;
    logic [ADDR_W-1:0]        r_k;
    logic                     r_bank;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [DATA_W-1:0] r_buf [DEPTH];
    logic signed [DATA_W-1:0] r_y;
    logic                     r_y_valid;
    logic                     r_overrun;

    logic [ADDR_W-1:0]        w_addr_a;
    logic signed [DATA_W-1:0] w_samp_a;
    logic signed [COEFF_W-1:0] w_coeff;
    logic signed [MUL_W-1:0]  w_mul_in;
    logic signed [PROD_W-1:0] w_mul_ext;
    logic signed [PROD_W-1:0] w_coeff_ext;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic                     w_last_k;

    lpf_coeff_bank #(
        .ADDR_W  (ADDR_W),
        .COEFF_W (COEFF_W)
    ) u_coeff_bank (
        .i_index (r_k),
        .i_bank  (r_bank),
        .o_coeff (w_coeff)
    );

    // Tap k=0 is the newest sample; older samples sit at decreasing addresses.
    assign w_addr_a = r_offset - r_k;
    assign w_samp_a = r_buf[w_addr_a];
    assign w_last_k = (r_k == ADDR_W'(LAST_K));

`ifdef FIR_SYM_FOLD_EN
    logic [ADDR_W-1:0]        w_addr_b;
    logic signed [DATA_W-1:0] w_samp_b;

    // Mirror taps share a coefficient; the centre tap is multiplied on its own.
    assign w_addr_b = r_offset - (ADDR_W'(NTAPS - 1) - r_k);
    assign w_samp_b = r_buf[w_addr_b];
    assign w_mul_in = w_last_k ? {w_samp_a[DATA_W-1], w_samp_a}
                               : {w_samp_a[DATA_W-1], w_samp_a} + {w_samp_b[DATA_W-1], w_samp_b};
`else
    assign w_mul_in = w_samp_a;
`endif

    assign w_mul_ext   = {{COEFF_W{w_mul_in[MUL_W-1]}}, w_mul_in};
    assign w_coeff_ext = {{MUL_W{w_coeff[COEFF_W-1]}}, w_coeff};
    assign w_prod      = w_mul_ext * w_coeff_ext;
    assign w_prod_ext  = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (ready) w_next_state = MAC;
            MAC:     if (w_last_k) w_next_state = OUT;
            OUT:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == MAC) || (r_state == OUT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_offset  <= '0;
            r_k       <= '0;
            r_bank    <= BANK_WN0625;
            r_acc     <= '0;
            r_y       <= '0;
            r_y_valid <= 1'b0;
            r_overrun <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_y_valid <= 1'b0;
            // A strobe during a pass is dropped without touching the buffer.
            r_overrun <= ready && (r_state != IDLE);
            case (r_state)
                IDLE: begin
                    if (ready) begin
                        r_buf[r_offset + ADDR_W'(1)] <= x;
                        r_offset <= r_offset + ADDR_W'(1);
                        r_bank   <= bank_sel;
                        r_acc    <= '0;
                        r_k      <= '0;
                    end
                end
                MAC: begin
                    r_acc <= r_acc + w_prod_ext;
                    r_k   <= r_k + ADDR_W'(1);
                end
                OUT: begin
                    r_y       <= r_acc[COEFF_FRAC +: DATA_W];
                    r_y_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign y       = r_y;
    assign y_valid = r_y_valid;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_fir_lpf_param.sv
// tb/tb_fir_lpf_param.sv - directed self-checking bench for fir_lpf_param (honours FIR_SYM_FOLD_EN latency)
module tb_fir_lpf_param;

`ifdef FIR_SYM_FOLD_EN
    localparam int LAT = 17;
`else
    localparam int LAT = 32;
`endif

    logic               clock;
    logic               reset;
    logic               ready;
    logic signed [15:0] x;
    logic               bank_sel;
    logic signed [15:0] y;
    logic               y_valid;
    logic               busy;
    logic               overrun;

    int n_pass  = 0;
    int n_total = 0;

    int c1 [31] = '{5, 6, 7, 10, 14, 19, 25, 31, 37, 43, 48, 53, 58, 61, 62, 63,
                    62, 61, 58, 53, 48, 43, 37, 31, 25, 19, 14, 10, 7, 6, 5};

    fir_lpf_param dut (
        .clock    (clock),
        .reset    (reset),
        .ready    (ready),
        .x        (x),
        .bank_sel (bank_sel),
        .y        (y),
        .y_valid  (y_valid),
        .busy     (busy),
        .overrun  (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic send(input int s, input logic b, output int yo);
        bit got;
        got = 1'b0;
        yo  = 0;
        ready    = 1'b1;
        x        = 16'(s);
        bank_sel = b;
        tick();
        ready = 1'b0;
        for (int n = 0; n < LAT + 8 && !got; n++) begin
            tick();
            if (y_valid) begin
                got = 1'b1;
                yo  = int'(y);
            end
        end
        check("send_done", int'(got), 1);
    endtask

    initial begin
        int yo, prev, yv_edge, yv_count, ycap, busy_end;
        bit busy_ok, mono, all_zero;

        reset = 1'b1;
        ready = 1'b0;
        x = '0;
        bank_sel = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_y", int'(y), 0);
        check("rst_y_valid", int'(y_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overrun", int'(overrun), 0);

        // Latency and handshake on the first impulse sample
        ready = 1'b1; x = 16'sd1024; bank_sel = 1'b1;
        tick();
        ready = 1'b0;
        busy_ok = busy; yv_edge = -1; yv_count = 0; ycap = 0; busy_end = 1;
        for (int e = 1; e <= LAT + 3; e++) begin
            tick();
            if (y_valid) begin
                yv_count++;
                if (yv_edge < 0) begin
                    yv_edge = e;
                    ycap = int'(y);
                end
            end
            if (e < LAT && !busy) busy_ok = 1'b0;
            if (e == LAT) busy_end = int'(busy);
        end
        check("lat_y_valid_edge", yv_edge, LAT);
        check("lat_y_valid_width", yv_count, 1);
        check("lat_busy_during", int'(busy_ok), 1);
        check("lat_busy_after", busy_end, 0);
        check("impulse_0", ycap, 5);

        for (int i = 1; i < 31; i++) begin
            send(0, 1'b1, yo);
            check($sformatf("impulse_%0d", i), yo, c1[i]);
        end
        send(0, 1'b1, yo);
        check("impulse_tail", yo, 0);

        // DC ramp and steady state, bank 1
        mono = 1'b1; prev = -1000000;
        for (int i = 0; i < 40; i++) begin
            send(1000, 1'b1, yo);
            if (i == 0) check("dc1_first", yo, 4);
            if (i == 2) check("dc1_third", yo, 17);
            if (i < 30 && yo < prev) mono = 1'b0;
            prev = yo;
        end
        check("dc1_monotone", int'(mono), 1);
        check("dc1_steady", yo, 997);

        // DC ramp and steady state, bank 0
        do_reset();
        mono = 1'b1; prev = -1000000;
        for (int i = 0; i < 40; i++) begin
            send(1000, 1'b0, yo);
            if (i == 0) check("dc0_first", yo, 0);
            if (i == 2) check("dc0_third", yo, 2);
            if (i < 30 && yo < prev) mono = 1'b0;
            prev = yo;
        end
        check("dc0_monotone", int'(mono), 1);
        check("dc0_steady", yo, 999);
        send(1000, 1'b1, yo);
        check("bank_switch", yo, 997);

        // Reset mid-MAC with a buffer full of 1000s
        ready = 1'b1; x = 16'sd1024; bank_sel = 1'b1;
        tick();
        ready = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstmac_busy", int'(busy), 0);
        check("rstmac_y", int'(y), 0);
        yv_count = 0;
        for (int e = 11; e <= LAT + 3; e++) begin
            tick();
            if (y_valid) yv_count++;
        end
        check("rstmac_no_valid", yv_count, 0);
        send(0, 1'b1, yo);
        check("rstmac_buf_clear", yo, 0);

        // Reset and ready together: reset wins
        reset = 1'b1; ready = 1'b1; x = 16'sd1024;
        tick();
        reset = 1'b0; ready = 1'b0;
        check("rst_ready_busy", int'(busy), 0);
        send(0, 1'b1, yo);
        check("rst_ready_dropped", yo, 0);

        // Overrun: second strobe while busy, bank_sel changed mid-pass
        do_reset();
        ready = 1'b1; x = 16'sd1024; bank_sel = 1'b1;
        tick();
        ready = 1'b0; bank_sel = 1'b0;
        repeat (4) tick();
        check("ovr_quiet", int'(overrun), 0);
        ready = 1'b1; x = 16'sd500;
        tick();
        ready = 1'b0;
        check("ovr_pulse", int'(overrun), 1);
        tick();
        check("ovr_clear", int'(overrun), 0);
        yv_edge = -1; ycap = 0;
        for (int e = 7; e <= LAT + 4; e++) begin
            tick();
            if (y_valid && yv_edge < 0) begin
                yv_edge = e;
                ycap = int'(y);
            end
        end
        check("ovr_valid_edge", yv_edge, LAT);
        check("ovr_result", ycap, 5);
        send(0, 1'b1, yo);
        check("ovr_offset_once", yo, 6);

        // Wrap: push the offset around the buffer several times, then impulse again
        do_reset();
        all_zero = 1'b1;
        for (int i = 0; i < 100; i++) begin
            send(0, 1'b1, yo);
            if (yo != 0) all_zero = 1'b0;
        end
        check("wrap_zeros", int'(all_zero), 1);
        send(1024, 1'b1, yo);
        check("wrap_impulse_0", yo, c1[0]);
        for (int i = 1; i < 31; i++) begin
            send(0, 1'b1, yo);
            check($sformatf("wrap_impulse_%0d", i), yo, c1[i]);
        end
        send(0, 1'b1, yo);
        check("wrap_tail", yo, 0);
        send(-1024, 1'b1, yo);
        check("neg_impulse", yo, -5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
